fetch_unit: RTL and testbench
=============================

# fetch_unit

Program counter, address multiplexer and two-byte instruction register for the 8-bit RISC CPU. Sits between the ROM/RAM data bus and the controller FSM. It captures the opcode and operand bytes when the controller asserts `fetch`, and presents the registered opcode to the controller's `ins` input. It also drives the shared memory address from either the PC or the operand byte, selected by `ad_sel`.

## Interface
- `AW`, 8: address width of PC and memory address bus (1..8).
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `fetch` input 2: from controller; 01 = load opcode byte, 10 = load operand byte, 00/11 = hold.
- `PC_en` input 1: increment PC at end of cycle.
- `ad_sel` input 1: 0 = `addr` driven from PC; 1 = `addr` driven from operand.
- `rom_read` input 1: ROM data valid on `data_in` this cycle.
- `data_in` input 8: ROM read data for the current `addr`.
- `ins` output 3: registered opcode (`ir_op[7:5]`) to controller.
- `reg_idx` output 5: registered `ir_op[4:0]`, register-file index.
- `operand` output 8: registered operand byte.
- `pc` output AW: current program counter.
- `addr` output AW: memory address; combinational, `ad_sel ? operand[AW-1:0] : pc`.
- `ir_valid` output 1: opcode and operand both captured for the current instruction.
- `brk_addr` input AW, `brk_hit` output 1: present only with `FETCH_BRK_EN`.

## Operation
- Reset values: `pc`=0, `ins`=000 (NOP), `reg_idx`=0, `operand`=0x00, `ir_valid`=0, `brk_hit`=0, FSM=`WAIT_OP`.
- PC: increments by 1 modulo 2^AW on any edge with `PC_en`=1. It wraps from 2^AW-1 to 0 with no flag.
- Opcode load, condition `fetch`=01 && `ad_sel`=0 && `rom_read`=1:
  - `ir_op` <= `data_in`.
  - `operand` <= 0x00.
  - FSM -> `HAVE_OP`.
  - `ir_valid` <= 0.
- `fetch`=01 with `ad_sel`=1 is a data load into the register file. It does not touch the IR, PC or FSM.
- Operand load, condition `fetch`=10 && `rom_read`=1 && FSM=`HAVE_OP`:
  - `operand` <= `data_in`.
  - FSM -> `HAVE_ALL`.
  - `ir_valid` <= 1.
- Subsequent `fetch`=10 cycles while in `HAVE_ALL` are ignored. The controller holds `fetch`=10 for two cycles, and only the first is captured.
- `fetch`=10 while in `WAIT_OP` is ignored. `rom_read`=0 blocks both loads.
- FSM transitions:
  - `WAIT_OP` -> `HAVE_OP` on opcode load.
  - `HAVE_OP` -> `HAVE_ALL` on operand load.
  - `HAVE_OP`/`HAVE_ALL` -> `HAVE_OP` on the next opcode load. A one-byte instruction never leaves `HAVE_OP`.
- `fetch`=11 is treated as hold.

## Timing
- `ins` updates on the edge that ends the opcode-load cycle (controller S0) and is valid throughout the next cycle (S1), where the controller decodes it.
- `operand` is valid in the cycle after its load (S4) and onward.
- PC increment and IR/operand load in the same cycle: the load samples `data_in` for the pre-increment `addr`. Both take effect on the same edge.
- `addr` is combinational from registered `pc`/`operand` and `ad_sel`. There is no path from `data_in` to `addr`.
- Reset asserted mid-instruction clears all state immediately, independent of `clk`. First opcode fetch after release is from address 0.

## Configuration
- Macro: `FETCH_BRK_EN`.
- Defined:
  - Adds ports `brk_addr` and `brk_hit`.
  - On an opcode load with `pc`==`brk_addr`, `ins` is forced to 111 (HLT) instead of `data_in[7:5]`.
  - `brk_hit` is set sticky; it clears only on reset.
  - `reg_idx` and the FSM update normally.
- Undefined: ports absent, no comparator, opcode always `data_in[7:5]`.

## Test plan
- Reset then release: `pc`=0, `ins`=000, `ir_valid`=0, `addr`=0 with `ad_sel`=0.
- LDA sequence:
  - Stimulus: `data_in`=0x45 on `fetch`=01, PC_en pulse, then 0x3C on two `fetch`=10 cycles with PC_en on the second.
  - Required: `ins`=010, `reg_idx`=5, `operand`=0x3C, `ir_valid`=1, `pc`=2. Driving `ad_sel`=1 gives `addr`=0x3C.
- Double-`fetch`=10 guard: `data_in` changes 0x3C -> 0x99 between the two `fetch`=10 cycles -> `operand` stays 0x3C.
- Data load isolation: `fetch`=01 with `ad_sel`=1 and `data_in`=0xFF -> `ins`, `reg_idx`, `pc` unchanged.
- Wrap: `pc`=0xFF with PC_en -> `pc`=0x00. Async reset pulse mid-operand-fetch -> all outputs at reset values before the next edge.
- With `FETCH_BRK_EN`: `brk_addr`=0x04 and opcode load at `pc`=4 with `data_in`=0x20 -> `ins`=111, `brk_hit`=1, stays 1 afterwards.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bus between the controller/memory side and fetch_unit.
// Breakpoint signals exist only when FETCH_BRK_EN is defined.
interface fetch_unit_if #(
    parameter int AW = 8
);
    // Control and ROM inputs are sampled on the rising clock edge.
    // There is no backpressure: rom_read marks data_in valid for the current
    // addr, and a load happens only in a cycle where rom_read is high.
    logic [1:0]    fetch;
    logic          PC_en;
    logic          ad_sel;
    logic          rom_read;
    logic [7:0]    data_in;
    logic [2:0]    ins;
    logic [4:0]    reg_idx;
    logic [7:0]    operand;
    logic [AW-1:0] pc;
    logic [AW-1:0] addr;
    logic          ir_valid;
    logic [1:0]    fsm_state;
`ifdef FETCH_BRK_EN
    logic [AW-1:0] brk_addr;
    logic          brk_hit;

    modport master (
        output fetch, PC_en, ad_sel, rom_read, data_in, brk_addr,
        input  ins, reg_idx, operand, pc, addr, ir_valid, fsm_state, brk_hit
    );
    modport slave (
        input  fetch, PC_en, ad_sel, rom_read, data_in, brk_addr,
        output ins, reg_idx, operand, pc, addr, ir_valid, fsm_state, brk_hit
    );
`else
    modport master (
        output fetch, PC_en, ad_sel, rom_read, data_in,
        input  ins, reg_idx, operand, pc, addr, ir_valid, fsm_state
    );
    modport slave (
        input  fetch, PC_en, ad_sel, rom_read, data_in,
        output ins, reg_idx, operand, pc, addr, ir_valid, fsm_state
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Program counter, address mux and two-byte instruction register.
// Optional breakpoint comparator is enabled with the FETCH_BRK_EN macro.
module fetch_unit #(
    parameter int AW = 8
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_OP  = 2'd0,
        HAVE_OP  = 2'd1,
        HAVE_ALL = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [2:0]    ins_q;
    logic [4:0]    reg_idx_q;
    logic [7:0]    operand_q;
    logic          ir_valid_q;
    logic          op_load;
    logic          opd_load;
    logic [2:0]    op_bits;
`ifdef FETCH_BRK_EN
    logic          brk_hit_q;
`endif

    always_comb begin
        // fetch=01 with ad_sel=1 is a register-file data load, not an opcode.
        op_load  = (bus.fetch == 2'b01) && !bus.ad_sel && bus.rom_read;
        opd_load = (bus.fetch == 2'b10) && bus.rom_read && (state_q == HAVE_OP);
        pc_d     = bus.PC_en ? pc_q + AW'(1) : pc_q;
        op_bits  = bus.data_in[7:5];
`ifdef FETCH_BRK_EN
        if (pc_q == bus.brk_addr) begin
            op_bits = 3'b111;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WAIT_OP;
            pc_q       <= '0;
            ins_q      <= 3'b000;
            reg_idx_q  <= 5'd0;
            operand_q  <= 8'h00;
            ir_valid_q <= 1'b0;
`ifdef FETCH_BRK_EN
            brk_hit_q  <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            if (op_load) begin
                ins_q      <= op_bits;
                reg_idx_q  <= bus.data_in[4:0];
                operand_q  <= 8'h00;
                ir_valid_q <= 1'b0;
                state_q    <= HAVE_OP;
`ifdef FETCH_BRK_EN
                if (pc_q == bus.brk_addr) begin
                    brk_hit_q <= 1'b1;
                end
`endif
            end else if (opd_load) begin
                operand_q  <= bus.data_in;
                ir_valid_q <= 1'b1;
                state_q    <= HAVE_ALL;
            end
        end
    end

    assign bus.ins       = ins_q;
    assign bus.reg_idx   = reg_idx_q;
    assign bus.operand   = operand_q;
    assign bus.pc        = pc_q;
    assign bus.addr      = bus.ad_sel ? operand_q[AW-1:0] : pc_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.fsm_state = state_q;
`ifdef FETCH_BRK_EN
    assign bus.brk_hit   = brk_hit_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequence followed by random
// cycles, all compared against a behavioural model of the fetch rules.
module tb_fetch_unit;
    localparam int AW = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if #(.AW(AW)) bus ();

    fetch_unit #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of architectural state.
    int        m_pc;
    logic [2:0] m_ins;
    logic [4:0] m_reg;
    logic [7:0] m_opd;
    logic       m_valid;
    bit         m_need_opd;
    bit         m_brk;
    logic [7:0] exp_q[$];
    logic [7:0] popped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 0;
        m_ins      = 3'b000;
        m_reg      = 5'd0;
        m_opd      = 8'h00;
        m_valid    = 1'b0;
        m_need_opd = 0;
        m_brk      = 0;
        exp_q.delete();
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       32'(bus.pc),       32'(m_pc));
        check({tag, ".ins"},      32'(bus.ins),      32'(m_ins));
        check({tag, ".reg_idx"},  32'(bus.reg_idx),  32'(m_reg));
        check({tag, ".operand"},  32'(bus.operand),  32'(m_opd));
        check({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(m_valid));
`ifdef FETCH_BRK_EN
        check({tag, ".brk_hit"},  32'(bus.brk_hit),  32'(m_brk));
`endif
    endtask

    // One clock cycle: drive inputs, check addr, clock, update model, check state.
    task automatic cyc(input string tag, input logic [1:0] f, input logic pcen,
                       input logic ads, input logic rr, input logic [7:0] din);
        bit opd_cap;
        bus.fetch    = f;
        bus.PC_en    = pcen;
        bus.ad_sel   = ads;
        bus.rom_read = rr;
        bus.data_in  = din;
        #1;
        check({tag, ".addr"}, 32'(bus.addr), ads ? 32'(m_opd) : 32'(m_pc));
        @(posedge clk);
        opd_cap = 0;
        if (f == 2'b01 && !ads && rr) begin
            m_ins = din[7:5];
`ifdef FETCH_BRK_EN
            if (m_pc == int'(bus.brk_addr)) begin
                m_ins = 3'b111;
                m_brk = 1;
            end
`endif
            m_reg      = din[4:0];
            m_opd      = 8'h00;
            m_valid    = 1'b0;
            m_need_opd = 1;
        end else if (f == 2'b10 && rr && m_need_opd) begin
            m_opd      = din;
            m_valid    = 1'b1;
            m_need_opd = 0;
            exp_q.push_back(din);
            opd_cap = 1;
        end
        if (pcen) m_pc = (m_pc + 1) % (1 << AW);
        #1;
        check_all(tag);
        if (opd_cap) begin
            popped = exp_q.pop_front();
            check({tag, ".captured"}, 32'(bus.operand), 32'(popped));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #7;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.fetch    = 2'b00;
        bus.PC_en    = 1'b0;
        bus.ad_sel   = 1'b0;
        bus.rom_read = 1'b0;
        bus.data_in  = 8'h00;
`ifdef FETCH_BRK_EN
        bus.brk_addr = 8'hEE;
`endif
        #2;
        do_reset();
        check_all("reset");
        check("reset.addr", 32'(bus.addr), 32'h0);

        // LDA: opcode 0x45, PC pulse, operand 0x3C then 0x99 on the held second cycle.
        cyc("lda_op",   2'b01, 1'b0, 1'b0, 1'b1, 8'h45);
        cyc("lda_pc",   2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("lda_opd1", 2'b10, 1'b0, 1'b0, 1'b1, 8'h3C);
        cyc("lda_opd2", 2'b10, 1'b1, 1'b0, 1'b1, 8'h99);
        check("lda.ins",      32'(bus.ins),      32'h2);
        check("lda.reg_idx",  32'(bus.reg_idx),  32'h5);
        check("lda.operand",  32'(bus.operand),  32'h3C);
        check("lda.ir_valid", 32'(bus.ir_valid), 32'h1);
        check("lda.pc",       32'(bus.pc),       32'h2);
        bus.ad_sel = 1'b1;
        #1;
        check("lda.addr_opd", 32'(bus.addr), 32'h3C);

        // Data load into register file leaves IR and PC alone.
        cyc("dload", 2'b01, 1'b0, 1'b1, 1'b1, 8'hFF);
        check("dload.ins", 32'(bus.ins), 32'h2);
        check("dload.pc",  32'(bus.pc),  32'h2);

        // Operand fetch in WAIT_OP, rom_read low, and fetch=11 are all ignored.
        do_reset();
        cyc("opd_wait", 2'b10, 1'b0, 1'b0, 1'b1, 8'h77);
        cyc("op_norr",  2'b01, 1'b0, 1'b0, 1'b0, 8'hA1);
        cyc("hold11",   2'b11, 1'b0, 1'b0, 1'b1, 8'hE3);
        check("ignored.ins", 32'(bus.ins), 32'h0);

        // PC wrap.
        for (int i = 0; i < 255; i++) cyc("walk", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap.pc_ff", 32'(bus.pc), 32'hFF);
        cyc("wrap", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap.pc_00", 32'(bus.pc), 32'h00);

        // Async reset mid operand fetch.
        cyc("ar_op", 2'b01, 1'b1, 1'b0, 1'b1, 8'hC7);
        cyc("ar_opd", 2'b10, 1'b1, 1'b0, 1'b1, 8'h5A);
        bus.fetch = 2'b10;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;

`ifdef FETCH_BRK_EN
        bus.brk_addr = 8'h04;
        for (int i = 0; i < 4; i++) cyc("brk_walk", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("brk_op", 2'b01, 1'b1, 1'b0, 1'b1, 8'h20);
        check("brk.ins", 32'(bus.ins), 32'h7);
        check("brk.hit", 32'(bus.brk_hit), 32'h1);
        cyc("brk_next", 2'b01, 1'b1, 1'b0, 1'b1, 8'h45);
        check("brk.sticky", 32'(bus.brk_hit), 32'h1);
        check("brk.ins2", 32'(bus.ins), 32'h2);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
